fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous-read FIFO into a valid/ready stream through a 2-entry skid buffer,
// framing the words into fixed-length bursts.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 256,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rd_en,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  burst_done,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  burst_done_q;
  logic                  pop;
  logic [2:0]            committed;

  // A slot freed by this cycle's pop may be refilled by a read issued in the same cycle.
  always_comb begin
    pop       = (occ_q != 2'd0) & m_ready;
    committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en     = en & ~rd_empty & ~rst & (committed < 3'd2);
  end

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_q;
    beat_d   = beat_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
      beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
    // Landing word goes to the tail slot left after any shift.
    if (inflight_q) begin
      if (occ_d == 2'd0) begin
        buf_d[0] = fifo_out;
      end else begin
        buf_d[1] = fifo_out;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
    end else begin
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
      occ_q        <= occ_d;
      inflight_q   <= rd_en;
      beat_q       <= beat_d;
      burst_done_q <= pop & m_last;
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf_q[0];
  assign m_last     = m_valid & (beat_q == LAST_BEAT);
  assign beat_cnt   = beat_q;
  assign burst_done = burst_done_q;
  assign busy       = (occ_q != 2'd0) | inflight_q;

  // A capture into a full buffer with no pop would overwrite a live entry.
  assert property (@(posedge rd_clk) disable iff (rst)
    !(inflight_q && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (BURST_LEN 4 and 1), each fed by a FIFO model
// and compared every cycle against a word-accounting reference model.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a  [2];
  logic rdy_a [2];
  int   wr_lim [2];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int BL = (gi == 0) ? 4 : 1;

    logic        rd_en, rd_empty, m_valid, m_last, burst_done, busy;
    logic [15:0] fifo_out = 16'h0;
    logic [15:0] m_data;
    logic [7:0]  beat_cnt;
    int          rd_ptr = 0;

    fifo_rd_stream #(.DATA_WIDTH(16), .BURST_LEN(BL), .CNT_WIDTH(8)) u_dut (
      .rd_clk(clk), .rst(rst), .en(en_a[gi]), .rd_en(rd_en), .rd_empty(rd_empty),
      .fifo_out(fifo_out), .m_valid(m_valid), .m_ready(rdy_a[gi]), .m_data(m_data),
      .m_last(m_last), .beat_cnt(beat_cnt), .burst_done(burst_done), .busy(busy)
    );

    // FIFO model: word i carries the value i; data arrives the cycle after the read.
    assign rd_empty = (rd_ptr >= wr_lim[gi]);
    always @(posedge clk) begin
      if (rd_en) begin
        fifo_out <= 16'(rd_ptr);
        rd_ptr   <= rd_ptr + 1;
      end
    end

    // Reference: words read but not yet delivered are consecutive, so the head word
    // is rd_ptr minus what is buffered and what is still in flight.
    int          avail = 0;
    int          pend  = 0;
    int          beat  = 0;
    bit          bd_exp = 1'b0;
    bit          clean  = 1'b1;
    bit          armed  = 1'b0;
    bit          pop, exp_valid, exp_rd;
    logic [15:0] head;

    always @(negedge clk) begin
      if (armed) begin
        exp_valid = (avail > 0);
        head      = 16'(rd_ptr - pend - avail);
        check_val($sformatf("u%0d m_valid", gi), 32'(m_valid), 32'(exp_valid));
        check_val($sformatf("u%0d busy", gi), 32'(busy), 32'((avail > 0) || (pend > 0)));
        check_val($sformatf("u%0d beat_cnt", gi), 32'(beat_cnt), 32'(beat));
        check_val($sformatf("u%0d m_last", gi), 32'(m_last), 32'(exp_valid && (beat == BL - 1)));
        check_val($sformatf("u%0d burst_done", gi), 32'(burst_done), 32'(bd_exp));
        if (exp_valid)
          check_val($sformatf("u%0d m_data", gi), 32'(m_data), 32'(head));
        else if (clean)
          check_val($sformatf("u%0d m_data_rst", gi), 32'(m_data), 32'h0);
        pop    = exp_valid && (rdy_a[gi] === 1'b1);
        exp_rd = en_a[gi] && !rd_empty && !rst && (avail + pend - int'(pop) < 2);
        check_val($sformatf("u%0d rd_en", gi), 32'(rd_en), 32'(exp_rd));
        if (rst) begin
          avail = 0; pend = 0; beat = 0; bd_exp = 1'b0; clean = 1'b1;
        end else begin
          bd_exp = pop && (beat == BL - 1);
          if (pop) begin
            avail = avail - 1;
            beat  = (beat == BL - 1) ? 0 : beat + 1;
          end
          if (pend > 0) begin
            avail = avail + 1;
            clean = 1'b0;
          end
          pend = (rd_en === 1'b1) ? 1 : 0;
          check_val($sformatf("u%0d overrun", gi), 32'(avail + pend <= 2), 32'h1);
        end
      end
      if (rst) armed = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      en_a[k] = 1'b0; rdy_a[k] = 1'b0; wr_lim[k] = 0;
    end
    cyc(3);
    rst = 1'b0;
    fork
      begin : seq_u0
        // Preloaded 0..7, full-rate drain
        wr_lim[0] = 8; en_a[0] = 1'b1; rdy_a[0] = 1'b1;
        cyc(12);
        // Ready pattern 1,0,0,1
        wr_lim[0] += 8;
        for (int i = 0; i < 32; i++) begin
          rdy_a[0] = (i % 4 == 0) || (i % 4 == 3);
          cyc(1);
        end
        rdy_a[0] = 1'b1;
        cyc(6);
        // FIFO runs dry mid-burst, then refills
        wr_lim[0] += 2; cyc(6);
        wr_lim[0] += 2; cyc(6);
        // en pulsed for one cycle, then resumed
        en_a[0] = 1'b0; wr_lim[0] += 4; cyc(1);
        en_a[0] = 1'b1; cyc(1);
        en_a[0] = 1'b0; cyc(6);
        en_a[0] = 1'b1; cyc(8);
        // Reset with a full buffer mid-burst
        wr_lim[0] += 10; rdy_a[0] = 1'b1; cyc(3);
        rdy_a[0] = 1'b0; cyc(3);
        rst = 1'b1; cyc(1);
        rst = 1'b0; rdy_a[0] = 1'b1; cyc(12);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
          en_a[0]  = ($urandom % 4) != 0;
          rdy_a[0] = ($urandom % 3) != 0;
          if ($urandom % 4 == 0) wr_lim[0] += int'($urandom % 3);
          rst = ($urandom % 97) == 0;
          cyc(1);
        end
        rst = 1'b0; en_a[0] = 1'b1; rdy_a[0] = 1'b1;
        cyc(20);
      end
      begin : seq_u1
        wr_lim[1] = 3; en_a[1] = 1'b1; rdy_a[1] = 1'b1;
        cyc(10);
        for (int i = 0; i < 400; i++) begin
          en_a[1]  = ($urandom % 4) != 0;
          rdy_a[1] = ($urandom % 2) != 0;
          if ($urandom % 3 == 0) wr_lim[1] += int'($urandom % 3);
          cyc(1);
        end
        en_a[1] = 1'b1; rdy_a[1] = 1'b1;
        cyc(20);
      end
    join
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
